// File: rtl/tt_response_checker.sv
// Truth-table sweeper: walks every input vector into a small combinational DUT,
// samples its response once per vector and scores it against a latched table.
module tt_response_checker #(
  parameter int N_IN   = 4,
  parameter int DWELL  = 20,
  parameter int SETTLE = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [2**N_IN-1:0]   expected_i,
  input  logic                 f_i,
  output logic [N_IN-1:0]      vec_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [N_IN:0]        err_count_o,
  output logic                 fail_seen_o,
  output logic [N_IN-1:0]      first_fail_o,
  output logic [2**N_IN-1:0]   captured_o
);
  localparam int NV = 2**N_IN;
  localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam int EW = N_IN + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [N_IN-1:0] vec_q;
  logic [NV-1:0]   exp_q;
  logic [NV-1:0]   cap_q;
  logic [EW-1:0]   err_q;
  logic [N_IN-1:0] first_q;
  logic            busy_q, done_q, pass_q, fail_seen_q;

  logic            sample, mism, last_cyc;
  logic [EW-1:0]   err_d;

  // err_d folds in a sample taking place on the same edge as the final wrap,
  // so pass is correct even when SETTLE == DWELL-1.
  always_comb begin
    sample   = (state_q == RUN) && (cnt_q == CW'(SETTLE));
    mism     = (f_i != exp_q[vec_q]);
    last_cyc = (cnt_q == CW'(DWELL - 1));
    err_d    = err_q + EW'(sample && mism);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vec_q       <= '0;
      exp_q       <= '0;
      cap_q       <= '0;
      err_q       <= '0;
      first_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_seen_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q     <= RUN;
            busy_q      <= 1'b1;
            vec_q       <= '0;
            cnt_q       <= '0;
            exp_q       <= expected_i;
            cap_q       <= '0;
            err_q       <= '0;
            first_q     <= '0;
            fail_seen_q <= 1'b0;
            pass_q      <= 1'b0;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + CW'(1);
          if (sample) begin
            cap_q[vec_q] <= f_i;
            err_q        <= err_d;
            if (mism && !fail_seen_q) begin
              first_q     <= vec_q;
              fail_seen_q <= 1'b1;
            end
          end
          if (last_cyc) begin
            cnt_q <= '0;
            if (&vec_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              vec_q   <= '0;
              pass_q  <= (err_d == '0);
            end else begin
              vec_q <= vec_q + N_IN'(1);
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vec_o        = vec_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign err_count_o  = err_q;
  assign fail_seen_o  = fail_seen_q;
  assign first_fail_o = first_q;
  assign captured_o   = cap_q;
endmodule

// File: tb/tb_tt_response_checker.sv
// Directed bench for tt_response_checker: a table of full sweeps against
// several emulated DUT responses, plus reset-abort and restart sequences.
module tb_tt_response_checker;
  localparam int N_IN = 4, DWELL = 20, SETTLE = 2;
  localparam int LAT  = 16 * DWELL;

  logic        clk, rst_n, start, f;
  logic [15:0] expected;
  logic [3:0]  vec;
  logic        busy, done, pass, fail_seen;
  logic [4:0]  err_count;
  logic [3:0]  first_fail;
  logic [15:0] captured;

  int total = 0, bad = 0;
  int cyc = 0, k = 0, mode = 0, phase;

  tt_response_checker #(.N_IN(N_IN), .DWELL(DWELL), .SETTLE(SETTLE)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .expected_i(expected),
    .f_i(f), .vec_o(vec), .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_count_o(err_count), .fail_seen_o(fail_seen),
    .first_fail_o(first_fail), .captured_o(captured));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Emulated lab circuit; mode 2 is only correct in the sample slot.
  always_comb begin
    phase = (cyc - k) % DWELL;
    case (mode)
      0:       f = ^vec;
      1:       f = ~^vec;
      2:       f = (phase == SETTLE) ? ^vec : ~^vec;
      default: f = 1'b0;
    endcase
  end

  typedef struct {
    int          mode;
    logic [15:0] e;
    int          err;
    logic        fs;
    logic [3:0]  ff;
    logic        ps;
    logic [15:0] cap;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic start_sweep(input logic [15:0] e);
    @(negedge clk);
    expected = e;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = cyc;
  endtask

  // Waits for done; flips the expected input mid-run to prove it is latched.
  task automatic wait_done(output int lat, output bit ok);
    ok = 0;
    lat = -1;
    for (int i = 0; i < LAT + 80; i++) begin
      @(negedge clk);
      if (i == 100) expected = ~expected;
      if (done) begin
        lat = cyc - k;
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_vec(input logic [3:0] v, output bit ok);
    ok = 0;
    for (int i = 0; i < LAT + 80; i++) begin
      @(negedge clk);
      if (vec == v && busy) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    int lat, dcnt;
    bit ok;
    tbl[0] = '{0, 16'h6996, 0,  1'b0, 4'd0,  1'b1, 16'h6996};
    tbl[1] = '{1, 16'h6996, 16, 1'b1, 4'd0,  1'b0, 16'h9669};
    tbl[2] = '{0, 16'h6D96, 1,  1'b1, 4'd10, 1'b0, 16'h6996};
    tbl[3] = '{2, 16'h6996, 0,  1'b0, 4'd0,  1'b1, 16'h6996};
    tbl[4] = '{3, 16'h0000, 0,  1'b0, 4'd0,  1'b1, 16'h0000};
    tbl[5] = '{0, 16'h8000, 9,  1'b1, 4'd1,  1'b0, 16'h6996};
    tbl[6] = '{1, 16'h9669, 0,  1'b0, 4'd0,  1'b1, 16'h9669};

    rst_n = 1'b0; start = 1'b0; expected = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {vec, busy, done, pass, err_count, fail_seen, first_fail, captured}, 32'h0);
    rst_n = 1'b1;

    foreach (tbl[t]) begin
      mode = tbl[t].mode;
      start_sweep(tbl[t].e);
      chk($sformatf("t%0d_busy", t), busy, 1'b1);
      wait_done(lat, ok);
      chk($sformatf("t%0d_done_seen", t), ok, 1'b1);
      chk($sformatf("t%0d_latency", t), lat, LAT);
      chk($sformatf("t%0d_err", t), err_count, tbl[t].err);
      chk($sformatf("t%0d_fail_seen", t), fail_seen, tbl[t].fs);
      if (tbl[t].fs) chk($sformatf("t%0d_first", t), first_fail, tbl[t].ff);
      chk($sformatf("t%0d_pass", t), pass, tbl[t].ps);
      chk($sformatf("t%0d_captured", t), captured, tbl[t].cap);
      chk($sformatf("t%0d_end_busy_vec", t), {busy, vec}, 5'h0);
      @(negedge clk);
      chk($sformatf("t%0d_done_width", t), done, 1'b0);
      chk($sformatf("t%0d_pass_held", t), pass, tbl[t].ps);
    end

    // Reset mid-sweep aborts with no done pulse.
    mode = 1;
    start_sweep(16'h6996);
    wait_vec(4'd7, ok);
    chk("abort_reach_vec7", ok, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_state", {busy, vec, err_count, done}, 11'h0);
    dcnt = 0;
    for (int i = 0; i < LAT + 40; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    mode = 0;
    start_sweep(16'h6996);
    wait_done(lat, ok);
    chk("after_abort_latency", lat, LAT);
    chk("after_abort_result", {pass, err_count, captured}, {1'b1, 5'd0, 16'h6996});

    // Start re-pulsed mid-sweep is ignored.
    start_sweep(16'h6996);
    wait_vec(4'd5, ok);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, ok);
    chk("restart_ignored_latency", lat, LAT);
    chk("restart_ignored_pass", pass, 1'b1);

    // Start held high: DONE -> IDLE -> new RUN on the following edge.
    start_sweep(16'h6996);
    start = 1'b1;
    wait_done(lat, ok);
    chk("held_latency", lat, LAT);
    @(negedge clk);
    chk("held_idle_gap", {busy, done}, 2'b00);
    @(negedge clk);
    start = 1'b0;
    k = cyc;
    chk("held_resweep_busy", {busy, vec}, 5'b1_0000);
    wait_done(lat, ok);
    chk("held_second_latency", lat, LAT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
